// File: rtl/c3po_egress_arb.sv
// c3po_egress_arb
//   Packet-atomic round-robin arbiter. Merges PORTS_P per-port unpacker flit
//   streams (32-byte flits) into a single registered egress stream. A port
//   that wins at SOP owns the egress until its EOP flit is accepted.
//
// Optional feature macro: C3PO_ARB_PKT_CNT_EN (per-port forwarded packet counters)
//
// Ports
//   clk        : rising-edge clock
//   reset_L    : asynchronous active-low reset
//   in_val     : [PORTS_P]       flit valid per port
//   in_sop     : [PORTS_P]       start of packet per port
//   in_eop     : [PORTS_P]       end of packet per port
//   in_vbc     : [PORTS_P][8]    valid byte count per port
//   in_data    : [PORTS_P][256]  flit data per port
//   in_ready   : [PORTS_P]       flit accepted when in_val & in_ready
//   out_val/out_sop/out_eop/out_vbc/out_data/out_port : registered egress flit
//   out_ready  : downstream accept
//   proto_err  : [PORTS_P]       pulse for each non-SOP flit dropped while idle
//   pkt_cnt    : [PORTS_P][CNT_SIZE_P] packets forwarded per port (zero unless macro)
module c3po_egress_arb #(
    parameter int PORTS_P    = 4,
    parameter int CNT_SIZE_P = 8
) (
    input  logic                                 clk,
    input  logic                                 reset_L,
    input  logic [PORTS_P-1:0]                   in_val,
    input  logic [PORTS_P-1:0]                   in_sop,
    input  logic [PORTS_P-1:0]                   in_eop,
    input  logic [PORTS_P-1:0][7:0]              in_vbc,
    input  logic [PORTS_P-1:0][255:0]            in_data,
    output logic [PORTS_P-1:0]                   in_ready,
    output logic                                 out_val,
    output logic                                 out_sop,
    output logic                                 out_eop,
    output logic [7:0]                           out_vbc,
    output logic [255:0]                         out_data,
    output logic [$clog2(PORTS_P)-1:0]           out_port,
    input  logic                                 out_ready,
    output logic [PORTS_P-1:0]                   proto_err,
    output logic [PORTS_P-1:0][CNT_SIZE_P-1:0]   pkt_cnt
);

    localparam int PW = $clog2(PORTS_P);
    typedef logic [PW-1:0] port_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t              r_state;
    port_t               r_lock_port;
    port_t               r_rr_ptr;
    logic                r_out_val;
    logic                r_out_sop;
    logic                r_out_eop;
    logic [7:0]          r_out_vbc;
    logic [255:0]        r_out_data;
    port_t               r_out_port;
    logic [PORTS_P-1:0]  r_proto_err;

    logic                w_acc;
    logic                w_locked;
    logic [PORTS_P-1:0]  w_req;
    logic [PORTS_P-1:0]  w_drop;
    logic                w_gnt_vld;
    port_t               w_gnt;
    int unsigned         w_scan_idx;
    port_t               w_sel;
    logic                w_xfer;
    logic                w_sel_eop;

    function automatic port_t next_port(input port_t p);
        return (int'(p) == PORTS_P - 1) ? '0 : port_t'(p + 1'b1);
    endfunction

    assign w_acc     = !r_out_val | out_ready;
    assign w_locked  = (r_state == S_LOCK);
    assign w_req     = in_val & in_sop;
    assign w_drop    = w_locked ? '0 : (in_val & ~in_sop);

    // Round-robin scan starting at r_rr_ptr, wrapping modulo PORTS_P.
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt      = '0;
        w_scan_idx = 0;
        for (int unsigned k = 0; k < unsigned'(PORTS_P); k++) begin
            w_scan_idx = (int'(r_rr_ptr) + k) % unsigned'(PORTS_P);
            if (!w_gnt_vld && w_req[w_scan_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = port_t'(w_scan_idx);
            end
        end
    end

    assign w_sel     = w_locked ? r_lock_port : w_gnt;
    assign w_xfer    = w_acc & (w_locked ? in_val[r_lock_port] : w_gnt_vld);
    assign w_sel_eop = in_eop[w_sel];

    // Drops are accepted regardless of the output stage; the granted port
    // always has SOP set, so it never overlaps the drop mask.
    always_comb begin
        in_ready = w_drop;
        if (w_locked) begin
            in_ready[r_lock_port] = w_acc;
        end else if (w_gnt_vld) begin
            in_ready[w_gnt] = w_acc;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= S_IDLE;
            r_lock_port <= '0;
            r_rr_ptr    <= '0;
            r_out_val   <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_vbc   <= '0;
            r_out_data  <= '0;
            r_out_port  <= '0;
            r_proto_err <= '0;
        end else begin
            r_proto_err <= w_drop;
            if (w_acc) begin
                r_out_val <= w_xfer;
                if (w_xfer) begin
                    r_out_sop  <= !w_locked;
                    r_out_eop  <= w_sel_eop;
                    r_out_vbc  <= in_vbc[w_sel];
                    r_out_data <= in_data[w_sel];
                    r_out_port <= w_sel;
                end
            end
            if (w_xfer) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_sel_eop) begin
                            r_rr_ptr <= next_port(w_gnt);
                        end else begin
                            r_state     <= S_LOCK;
                            r_lock_port <= w_gnt;
                        end
                    end
                    S_LOCK: begin
                        if (w_sel_eop) begin
                            r_state  <= S_IDLE;
                            r_rr_ptr <= next_port(r_lock_port);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign out_val   = r_out_val;
    assign out_sop   = r_out_sop;
    assign out_eop   = r_out_eop;
    assign out_vbc   = r_out_vbc;
    assign out_data  = r_out_data;
    assign out_port  = r_out_port;
    assign proto_err = r_proto_err;

`ifdef C3PO_ARB_PKT_CNT_EN
    logic [PORTS_P-1:0][CNT_SIZE_P-1:0] r_pkt_cnt;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_pkt_cnt <= '0;
        end else if (w_xfer && w_sel_eop) begin
            r_pkt_cnt[w_sel] <= r_pkt_cnt[w_sel] + 1'b1;
        end
    end

    assign pkt_cnt = r_pkt_cnt;
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_c3po_egress_arb.sv
// Testbench for c3po_egress_arb (PORTS_P = 4, CNT_SIZE_P = 8).
// Table of single-cycle idle vectors plus scoreboarded multi-cycle sequences.
module tb_c3po_egress_arb;

    localparam int P = 4;

    logic                clk = 1'b0;
    logic                reset_L;
    logic [P-1:0]        in_val, in_sop, in_eop, in_ready;
    logic [P-1:0][7:0]   in_vbc;
    logic [P-1:0][255:0] in_data;
    logic                out_val, out_sop, out_eop, out_ready;
    logic [7:0]          out_vbc;
    logic [255:0]        out_data;
    logic [1:0]          out_port;
    logic [P-1:0]        proto_err;
    logic [P-1:0][7:0]   pkt_cnt;

    c3po_egress_arb #(.PORTS_P(P), .CNT_SIZE_P(8)) dut (
        .clk(clk), .reset_L(reset_L),
        .in_val(in_val), .in_sop(in_sop), .in_eop(in_eop),
        .in_vbc(in_vbc), .in_data(in_data), .in_ready(in_ready),
        .out_val(out_val), .out_sop(out_sop), .out_eop(out_eop),
        .out_vbc(out_vbc), .out_data(out_data), .out_port(out_port),
        .out_ready(out_ready), .proto_err(proto_err), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sop;
        logic         eop;
        logic [7:0]   vbc;
        logic [255:0] data;
    } flit_t;

    typedef struct {
        logic [1:0] port;
        flit_t      f;
    } exp_t;

    typedef struct {
        logic [3:0] val;
        logic [3:0] sop;
        logic [3:0] exp_rdy;
        logic [3:0] exp_perr;
        logic       exp_oval;
        logic [1:0] exp_port;
    } vec_t;

    flit_t  srcq[P][$];
    exp_t   expq[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     first_cyc = -1;
    int     last_cyc = -1;
    logic [3:0] guard = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_pkt(input int p, input int n, input logic [7:0] vlast);
        flit_t f;
        exp_t  e;
        for (int i = 0; i < n; i++) begin
            f.sop  = (i == 0);
            f.eop  = (i == n - 1);
            f.vbc  = (i == n - 1) ? vlast : 8'd32;
            f.data = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
            srcq[p].push_back(f);
            e.port = 2'(p);
            e.f    = f;
            expq.push_back(e);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < P; p++) begin
            if (srcq[p].size() > 0) begin
                in_val[p]  = 1'b1;
                in_sop[p]  = srcq[p][0].sop;
                in_eop[p]  = srcq[p][0].eop;
                in_vbc[p]  = srcq[p][0].vbc;
                in_data[p] = srcq[p][0].data;
            end else begin
                in_val[p]  = 1'b0;
                in_sop[p]  = 1'b0;
                in_eop[p]  = 1'b0;
                in_vbc[p]  = '0;
                in_data[p] = '0;
            end
        end
    endtask

    // One clock: sample/score at negedge, retire accepted source flits and
    // present the next heads just after the rising edge.
    task automatic cycle();
        logic [P-1:0] m;
        exp_t e;
        @(negedge clk);
        cyc++;
        if (guard != 0) chk("guard_ready", 256'(in_ready & guard), 256'(0));
        if (out_val && out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flit: got port %0d vbc %0d expected none", out_port, out_vbc);
            end else begin
                e = expq.pop_front();
                chk("sb_port", 256'(out_port), 256'(e.port));
                chk("sb_sop",  256'(out_sop),  256'(e.f.sop));
                chk("sb_eop",  256'(out_eop),  256'(e.f.eop));
                chk("sb_vbc",  256'(out_vbc),  256'(e.f.vbc));
                chk("sb_data", out_data, e.f.data);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
        m = in_val & in_ready;
        @(posedge clk);
        #1;
        for (int p = 0; p < P; p++) begin
            if (m[p]) void'(srcq[p].pop_front());
        end
        drive();
    endtask

    function automatic bit busy();
        bit b = (expq.size() > 0);
        for (int p = 0; p < P; p++) if (srcq[p].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input string nm, input int limit);
        int n = 0;
        while (busy() && n < limit) begin
            cycle();
            n++;
        end
        chk(nm, 256'(expq.size()), 256'(0));
        repeat (2) cycle();
    endtask

    task automatic clear_all();
        for (int p = 0; p < P; p++) srcq[p].delete();
        expq.delete();
        drive();
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        reset_L   = 1'b1;
        first_cyc = -1;
        last_cyc  = -1;
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{val: 4'b0000, sop: 4'b0000, exp_rdy: 4'b0000, exp_perr: 4'b0000, exp_oval: 1'b0, exp_port: 2'd0};
        vecs[1] = '{val: 4'b0100, sop: 4'b0000, exp_rdy: 4'b0100, exp_perr: 4'b0100, exp_oval: 1'b0, exp_port: 2'd0};
        vecs[2] = '{val: 4'b1111, sop: 4'b1111, exp_rdy: 4'b0001, exp_perr: 4'b0000, exp_oval: 1'b1, exp_port: 2'd0};
        vecs[3] = '{val: 4'b1010, sop: 4'b1000, exp_rdy: 4'b1010, exp_perr: 4'b0010, exp_oval: 1'b1, exp_port: 2'd3};
        vecs[4] = '{val: 4'b0110, sop: 4'b0110, exp_rdy: 4'b0010, exp_perr: 4'b0000, exp_oval: 1'b1, exp_port: 2'd1};
        vecs[5] = '{val: 4'b1101, sop: 4'b0100, exp_rdy: 4'b1101, exp_perr: 4'b1001, exp_oval: 1'b1, exp_port: 2'd2};
        vecs[6] = '{val: 4'b0000, sop: 4'b1111, exp_rdy: 4'b0000, exp_perr: 4'b0000, exp_oval: 1'b0, exp_port: 2'd0};
        vecs[7] = '{val: 4'b1111, sop: 4'b0000, exp_rdy: 4'b1111, exp_perr: 4'b1111, exp_oval: 1'b0, exp_port: 2'd0};

        out_ready = 1'b1;
        reset_L   = 1'b0;
        clear_all();
        #2;
        chk("rst_out_val",   256'(out_val), 256'(0));
        chk("rst_out_sop",   256'(out_sop), 256'(0));
        chk("rst_out_eop",   256'(out_eop), 256'(0));
        chk("rst_out_vbc",   256'(out_vbc), 256'(0));
        chk("rst_out_data",  out_data, 256'(0));
        chk("rst_out_port",  256'(out_port), 256'(0));
        chk("rst_proto_err", 256'(proto_err), 256'(0));
        chk("rst_pkt_cnt",   256'(pkt_cnt), 256'(0));
        chk("rst_in_ready",  256'(in_ready), 256'(0));

        // Idle arbitration/drop vectors, each from a fresh reset (rr_ptr = 0).
        for (int i = 0; i < 8; i++) begin
            do_reset();
            in_val = vecs[i].val;
            in_sop = vecs[i].sop;
            in_eop = '1;
            for (int p = 0; p < P; p++) begin
                in_vbc[p]  = 8'(i + 1);
                in_data[p] = {8{$urandom()}};
            end
            @(negedge clk);
            chk("tbl_ready", 256'(in_ready), 256'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            drive();
            chk("tbl_perr", 256'(proto_err), 256'(vecs[i].exp_perr));
            chk("tbl_oval", 256'(out_val), 256'(vecs[i].exp_oval));
            if (vecs[i].exp_oval) begin
                chk("tbl_port", 256'(out_port), 256'(vecs[i].exp_port));
                chk("tbl_sop",  256'(out_sop), 256'(1));
                chk("tbl_vbc",  256'(out_vbc), 256'(i + 1));
            end
            @(posedge clk);
            #1;
            chk("tbl_perr_clr", 256'(proto_err), 256'(0));
        end

        // Four simultaneous 3-flit packets: order 0,1,2,3 back to back.
        do_reset();
        for (int p = 0; p < P; p++) push_pkt(p, 3, 8'(5 + p));
        drive();
        drain("rr4_drain", 100);
        chk("rr4_span", 256'(last_cyc - first_cyc), 256'(11));

        // Port 1 4-flit packet with mid-packet stall; port 2 waits. rr_ptr = 0.
        push_pkt(1, 4, 8'd7);
        push_pkt(2, 2, 8'd3);
        guard = 4'b0100;
        drive();
        cycle();
        cycle();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            cycle();
            chk("stall_val",  256'(out_val), 256'(1));
            chk("stall_port", 256'(out_port), 256'(expq[0].port));
            chk("stall_sop",  256'(out_sop), 256'(expq[0].f.sop));
            chk("stall_vbc",  256'(out_vbc), 256'(expq[0].f.vbc));
            chk("stall_data", out_data, expq[0].f.data);
        end
        out_ready = 1'b1;
        cycle();
        cycle();
        guard = '0;
        drain("stall_drain", 100);

        // Single-flit packets on ports 3 and 0 alternate (rr_ptr = 3 now).
        first_cyc = -1;
        for (int k = 0; k < 4; k++) begin
            push_pkt(3, 1, 8'd17);
            push_pkt(0, 1, 8'd17);
        end
        drive();
        drain("alt_drain", 100);
        chk("alt_span", 256'(last_cyc - first_cyc), 256'(7));

        // Reset mid-packet on port 0 (rr_ptr = 1 before reset).
        push_pkt(0, 3, 8'd11);
        drive();
        cycle();
        cycle();
        chk("midrst_pre_val", 256'(out_val), 256'(1));
        reset_L = 1'b0;
        #1;
        chk("midrst_val",  256'(out_val), 256'(0));
        chk("midrst_sop",  256'(out_sop), 256'(0));
        chk("midrst_eop",  256'(out_eop), 256'(0));
        chk("midrst_vbc",  256'(out_vbc), 256'(0));
        chk("midrst_data", out_data, 256'(0));
        chk("midrst_port", 256'(out_port), 256'(0));
        chk("midrst_perr", 256'(proto_err), 256'(0));
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;
        begin
            flit_t f;
            f.sop  = 1'b0;
            f.eop  = 1'b1;
            f.vbc  = 8'd11;
            f.data = {8{$urandom()}};
            srcq[0].push_back(f);
        end
        drive();
        cycle();
        chk("midrst_drop_perr", 256'(proto_err), 256'(4'b0001));
        chk("midrst_drop_oval", 256'(out_val), 256'(0));
        cycle();
        push_pkt(0, 3, 8'd13);
        push_pkt(3, 1, 8'd2);
        drive();
        drain("midrst_drain", 100);

        // 257 packets from port 1: counter wraps to 1.
        do_reset();
        for (int k = 0; k < 257; k++) push_pkt(1, 1, 8'd9);
        drive();
        drain("cnt_drain", 600);
`ifdef C3PO_ARB_PKT_CNT_EN
        chk("pkt_cnt", 256'(pkt_cnt), 256'(32'h0000_0100));
`else
        chk("pkt_cnt", 256'(pkt_cnt), 256'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/c3po_egress_arb.md
# c3po_egress_arb

Packet-atomic round-robin arbiter merging the PORTS_P per-port unpacker output streams (32-byte flits) into one egress stream. Sits downstream of the per-port unpacker slices in c3po. Once a port wins at SOP it holds the egress until its EOP flit is accepted. Output is a single registered stage with a valid/ready handshake and backpressure to each port.

## Interface
- PORTS_P, 4, number of input streams (2..16)
- CNT_SIZE_P, 8, width of per-port packet counters (used only with C3PO_ARB_PKT_CNT_EN)
- clk  input  1  clock, all logic on rising edge
- reset_L  input  1  asynchronous, active-low reset
- in_val  input  PORTS_P  flit valid per port
- in_sop  input  PORTS_P  start of packet per port
- in_eop  input  PORTS_P  end of packet per port
- in_vbc  input  PORTS_P x 8  valid byte count per port (1..32)
- in_data  input  PORTS_P x 256  flit data per port
- in_ready  output  PORTS_P  flit accepted this cycle when in_val[i] & in_ready[i]
- out_val, out_sop, out_eop  output  1 each  egress flit qualifiers
- out_vbc  output  8  egress byte count
- out_data  output  256  egress data
- out_port  output  $clog2(PORTS_P)  source port of the current egress flit
- out_ready  input  1  downstream accept
- proto_err  output  PORTS_P  one-cycle pulse per port whose non-SOP flit was dropped while idle
- pkt_cnt  output  PORTS_P x CNT_SIZE_P  packets forwarded per port (only with macro)

## Operation
- acc = !out_val | out_ready. This is the output register load enable.
- FSM states: IDLE, LOCK. Registers: lock_port, rr_ptr (next port with highest priority).
- IDLE:
  - req[i] = in_val[i] & in_sop[i].
  - Grant g is the first set req scanning rr_ptr, rr_ptr+1, … with modulo-PORTS_P wrap.
  - in_ready[g] = acc.
  - On transfer: load the output register with port g's flit and set out_port = g.
  - If that flit has eop (single-flit packet), stay IDLE and set rr_ptr = g+1 mod PORTS_P.
  - Otherwise go to LOCK with lock_port = g.
- IDLE drop path: a port with in_val & !in_sop gets in_ready = 1 and its flit is discarded. proto_err[i] pulses next cycle. Drops happen for all such ports in the same cycle, independent of acc and of the grant.
- LOCK:
  - in_ready[lock_port] = acc. All other ports see in_ready = 0 (no drops).
  - in_sop on the locked port is ignored; data is forwarded and out_sop = 0.
  - An accepted flit with eop returns the FSM to IDLE and sets rr_ptr = lock_port+1 mod PORTS_P.
- in_vbc and in_data pass through unmodified; out_eop is copied from the input flit.
- out_sop = 1 only on the first flit of a packet.
- The output register holds all fields stable while out_val & !out_ready.

## Timing
- Reset values (async, immediate):
  - out_val, out_sop, out_eop, out_vbc, out_data, out_port, proto_err, pkt_cnt = 0.
  - FSM = IDLE, rr_ptr = 0, lock_port = 0.
- in_ready is combinational from FSM state, in_val/in_sop, out_val and out_ready. There is no path from in_data.
- Latency: an input flit accepted in cycle N appears on out_* in cycle N+1.
- Throughput: 1 flit/cycle while out_ready = 1, including back-to-back packets from different ports. The IDLE grant happens in the same cycle the EOP-returned FSM is IDLE.
- out_val clears the cycle after acceptance if no new flit was loaded.
- Reset asserted mid-packet: the partial packet is abandoned. After release, the next flit from that port without SOP is dropped with proto_err.

## Configuration
- C3PO_ARB_PKT_CNT_EN defined:
  - pkt_cnt[i] increments by 1 on each accepted EOP flit from port i.
  - Counters wrap at 2^CNT_SIZE_P.
  - Reset value is 0.
- Not defined: pkt_cnt is tied to 0 and no counter flops are instantiated.

## Test plan
- Ports 0..3 each present one 3-flit packet simultaneously, out_ready = 1.
  - Required: egress order port 0,1,2,3, 12 consecutive flits.
  - out_sop on flits 1,4,7,10; out_eop on flits 3,6,9,12.
  - out_port is constant within each packet.
- Port 1 sends a 4-flit packet while port 2 holds a SOP flit. Hold out_ready = 0 for 3 cycles mid-packet.
  - Required: out_* stable while stalled.
  - Port 2 is not granted until port 1's EOP is accepted.
  - in_ready[2] = 0 throughout.
- Port 3 sends single-flit packets (sop = eop = 1, vbc = 17) continuously and port 0 does the same.
  - Required: strict alternation 3,0,3,0…, one flit per cycle.
  - out_vbc = 17 on every flit.
- In IDLE, port 2 presents val = 1, sop = 0.
  - Required: in_ready[2] = 1 in the same cycle, proto_err = 4'b0100 next cycle, out_val = 0.
- Assert reset_L = 0 during the 2nd flit of a port 0 packet, release, then resend a full packet.
  - Required: outputs are 0 immediately and rr_ptr = 0.
  - The new packet is forwarded intact with out_sop on its first flit.
- With C3PO_ARB_PKT_CNT_EN and CNT_SIZE_P = 8, forward 257 packets from port 1.
  - Required: pkt_cnt[1] = 1, all other entries = 0.
